// File: rtl/circle_chase_ctrl.sv
// circle_chase_ctrl: walks a lit circle around the HEX0..HEX(N-1) ring.
// Position p runs 0..2N-1; p<N is the upper circle (right-to-left),
// p>=N the lower circle coming back. A prescaler sets the step rate,
// and a debounced pause key toggles between RUN and PAUSE.
// Optional build macro: CIRCLE_CHASE_BOUNCE_EN (ping-pong instead of wrap).
//
// state   | meaning
// S_IDLE  | disabled; position and prescaler held at 0
// S_RUN   | prescaler counting; position advances on terminal count
// S_PAUSE | prescaler and position frozen until the next key press
module circle_chase_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BASE_TICKS = 12_500_000,
    parameter int unsigned DEB_TICKS  = 500_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic [1:0] speed_i,
    input  logic       pause_ni,
    output logic [2:0] row_index_o,
    output logic       column_index_o,
    output logic       step_o,
    output logic       lap_o,
    output logic       running_o
);

    localparam int unsigned RING_LEN = 2 * NUM_DIGITS;
    localparam int unsigned PW       = $clog2(RING_LEN);
    localparam int unsigned CW       = $clog2(BASE_TICKS);
    localparam int unsigned DW       = $clog2(DEB_TICKS + 1);

    localparam logic [PW-1:0] P_LAST  = PW'(RING_LEN - 1);
    localparam logic [PW-1:0] P_UPPER = PW'(NUM_DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]    en_sync_q;
    logic [1:0]    pause_sync_q;
    logic          en_s;
    logic          pause_s;

    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          key_q, key_d;
    logic          press;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          lap_q, lap_d;
    logic [2:0]    row_q, row_d;
    logic          col_q, col_d;

    logic [31:0]   period_m1;
    logic          tc;
    logic [PW-1:0] p_step;
    logic          lap_step;

`ifdef CIRCLE_CHASE_BOUNCE_EN
    logic          dir_q, dir_d;
    logic          dir_step;
`endif

    // Two-flop synchronizers; the pause key idles high (released).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_sync_q    <= 2'b00;
            pause_sync_q <= 2'b11;
        end else begin
            en_sync_q    <= {en_sync_q[0], en_i};
            pause_sync_q <= {pause_sync_q[0], pause_ni};
        end
    end

    assign en_s    = en_sync_q[1];
    assign pause_s = pause_sync_q[1];

    // Debounce: a new key level is accepted after DEB_TICKS differing samples in a row.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        key_d     = key_q;
        press     = 1'b0;
        if (pause_s == key_q) begin
            deb_cnt_d = '0;
        end else if (32'(deb_cnt_q) >= DEB_TICKS - 1) begin
            deb_cnt_d = '0;
            key_d     = pause_s;
            press     = ~pause_s;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    // Terminal count uses >= so a mid-count speed-up fires on the next cycle.
    assign period_m1 = (32'(BASE_TICKS) >> speed_i) - 32'd1;
    assign tc        = (32'(cnt_q) >= period_m1);

    // Next ring position for a step, plus lap/reversal flag.
    always_comb begin
        p_step   = p_q;
        lap_step = 1'b0;
`ifdef CIRCLE_CHASE_BOUNCE_EN
        dir_step = dir_q;
        if (dir_q) begin
            if (p_q == '0) begin
                // only reachable when started backward from p=0: bounce off the end
                p_step   = PW'(1);
                dir_step = 1'b0;
                lap_step = 1'b1;
            end else begin
                p_step = p_q - PW'(1);
                if (p_q == PW'(1)) begin
                    dir_step = 1'b0;
                    lap_step = 1'b1;
                end
            end
        end else begin
            p_step = p_q + PW'(1);
            if (p_q == P_LAST - PW'(1)) begin
                dir_step = 1'b1;
                lap_step = 1'b1;
            end
        end
`else
        if (dir_i) begin
            if (p_q == '0) begin
                p_step   = P_LAST;
                lap_step = 1'b1;
            end else begin
                p_step = p_q - PW'(1);
            end
        end else begin
            if (p_q == P_LAST) begin
                p_step   = '0;
                lap_step = 1'b1;
            end else begin
                p_step = p_q + PW'(1);
            end
        end
`endif
    end

    // Sequencer FSM: loss of enable beats a simultaneous press.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        lap_d   = 1'b0;
`ifdef CIRCLE_CHASE_BOUNCE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                p_d   = '0;
                cnt_d = '0;
                if (en_s) begin
                    state_d = S_RUN;
`ifdef CIRCLE_CHASE_BOUNCE_EN
                    dir_d   = dir_i;
`endif
                end
            end
            S_RUN: begin
                if (!en_s) begin
                    state_d = S_IDLE;
                    p_d     = '0;
                    cnt_d   = '0;
                end else if (press) begin
                    state_d = S_PAUSE;
                end else if (tc) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    p_d    = p_step;
                    lap_d  = lap_step;
`ifdef CIRCLE_CHASE_BOUNCE_EN
                    dir_d  = dir_step;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAUSE: begin
                if (!en_s) begin
                    state_d = S_IDLE;
                    p_d     = '0;
                    cnt_d   = '0;
                end else if (press) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                p_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Map the next position onto (row, column) so outputs move with step_o.
    always_comb begin
        if (p_d < P_UPPER) begin
            row_d = 3'(p_d);
            col_d = 1'b0;
        end else begin
            row_d = 3'(P_LAST - p_d);
            col_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt_q <= '0;
            key_q     <= 1'b1;
            state_q   <= S_IDLE;
            p_q       <= '0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            lap_q     <= 1'b0;
            row_q     <= 3'd0;
            col_q     <= 1'b0;
`ifdef CIRCLE_CHASE_BOUNCE_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            deb_cnt_q <= deb_cnt_d;
            key_q     <= key_d;
            state_q   <= state_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            lap_q     <= lap_d;
            row_q     <= row_d;
            col_q     <= col_d;
`ifdef CIRCLE_CHASE_BOUNCE_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign row_index_o    = row_q;
    assign column_index_o = col_q;
    assign step_o         = step_q;
    assign lap_o          = lap_q;
    assign running_o      = (state_q == S_RUN);

endmodule
